// File: rtl/piso_serial_scheduler_if.sv
// ============================================================================
// Module   : piso_serial_scheduler_if
// Brief    : Requester/serial-link bundle shared by the PISO scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface piso_serial_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  localparam int c_idx_w = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       grant;
  logic                     serial_out;
  logic                     frame_valid;
  logic                     frame_start;
  logic                     frame_last;
  logic [c_idx_w-1:0]       owner;
  logic                     busy;

  modport master (
    output req, data_in,
    input  grant, serial_out, frame_valid, frame_start, frame_last, owner, busy
  );

  modport slave (
    input  req, data_in,
    output grant, serial_out, frame_valid, frame_start, frame_last, owner, busy
  );
endinterface

`default_nettype wire

// File: rtl/piso_serial_scheduler.sv
// ============================================================================
// Module   : piso_serial_scheduler
// Brief    : Round-robin shared parallel-in/serial-out shifter with framing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serial_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  piso_serial_scheduler_if.slave bus
);
  localparam int                 c_idx_w    = $clog2(NUM_REQ);
  localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_bit_top  = c_cnt_w'(WIDTH - 1);
  localparam logic [3:0]         c_gap_load = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [c_idx_w-1:0] c_rr_init  = c_idx_w'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [WIDTH-1:0]     r_shift, w_shift_next;
  logic [c_cnt_w-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic [3:0]           r_gap_cnt, w_gap_cnt_next;
  logic [NUM_REQ-1:0]   r_grant, w_grant_next;
  logic [c_idx_w-1:0]   r_owner, w_owner_next;
  logic [c_idx_w-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic                 w_found;
  logic [c_idx_w-1:0]   w_winner;
  int                   w_idx;

  // Search starts one past the last winner so the last winner has lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = c_idx_w'(w_idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_grant   <= '0;
      r_owner   <= '0;
      r_rr_ptr  <= c_rr_init;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_gap_cnt <= w_gap_cnt_next;
      r_grant   <= w_grant_next;
      r_owner   <= w_owner_next;
      r_rr_ptr  <= w_rr_ptr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_gap_cnt_next = r_gap_cnt;
    w_grant_next   = '0;
    w_owner_next   = r_owner;
    w_rr_ptr_next  = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_shift_next           = bus.data_in[int'(w_winner)*WIDTH +: WIDTH];
          w_bit_cnt_next         = c_bit_top;
          w_owner_next           = w_winner;
          w_rr_ptr_next          = w_winner;
          w_grant_next[w_winner] = 1'b1;
          w_state_next           = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift_next   = {r_shift[WIDTH-2:0], 1'b0};
        w_bit_cnt_next = r_bit_cnt - c_cnt_w'(1);
        if (r_bit_cnt == '0) begin
          w_bit_cnt_next = '0;
          if (GAP_CYCLES > 0) begin
            w_state_next   = ST_GAP;
            w_gap_cnt_next = c_gap_load;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) w_state_next = ST_IDLE;
        else                 w_gap_cnt_next = r_gap_cnt - 4'd1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Frame outputs decode straight from registered state so reset clears them at once.
  assign bus.frame_valid = (r_state == ST_SHIFT);
  assign bus.serial_out  = bus.frame_valid & r_shift[WIDTH-1];
  assign bus.frame_start = bus.frame_valid && (r_bit_cnt == c_bit_top);
  assign bus.frame_last  = bus.frame_valid && (r_bit_cnt == '0);
  assign bus.busy        = (r_state == ST_SHIFT) || (r_state == ST_GAP);
  assign bus.grant       = r_grant;
  assign bus.owner       = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_piso_serial_scheduler.sv
// ============================================================================
// Module   : tb_piso_serial_scheduler
// Brief    : Scoreboarded bench for the round-robin PISO scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serial_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  piso_serial_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus_a ();
  piso_serial_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus_b ();

  piso_serial_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .GAP_CYCLES(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  piso_serial_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .GAP_CYCLES(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));

  typedef struct packed {
    logic [1:0]       owner;
    logic [WIDTH-1:0] word;
  } frame_t;

  frame_t           exp_q[$];
  frame_t           mon_exp;
  logic [WIDTH-1:0] mon_word;
  logic [1:0]       mon_owner;
  int               mon_bits;
  bit               mon_in_frame;

  // Frame monitor on the GAP_CYCLES=1 instance: rebuild each word, pop and compare.
  always @(negedge clock) begin
    if (!reset_n) begin
      mon_in_frame = 1'b0;
      mon_bits     = 0;
    end else if (bus_a.frame_valid) begin
      if (bus_a.frame_start) begin
        mon_in_frame = 1'b1;
        mon_bits     = 0;
        mon_word     = '0;
        mon_owner    = bus_a.owner;
      end
      if (mon_in_frame) begin
        mon_word = {mon_word[WIDTH-2:0], bus_a.serial_out};
        mon_bits++;
        if (bus_a.frame_last) begin
          mon_in_frame = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame owner=%0d word=%h, none expected", mon_owner, mon_word);
          end else begin
            mon_exp = exp_q.pop_front();
            if ({mon_owner, mon_word} !== mon_exp || mon_bits != WIDTH) begin
              errors++;
              $display("FAIL frame_word got owner=%0d word=%h bits=%0d, expected owner=%0d word=%h bits=%0d",
                       mon_owner, mon_word, mon_bits, mon_exp.owner, mon_exp.word, WIDTH);
            end
          end
        end
      end
    end else begin
      checks++;
      if (bus_a.serial_out !== 1'b0) begin
        errors++;
        $display("FAIL idle_serial got %b expected 0", bus_a.serial_out);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_a.busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b expected 0", bus_a.busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({bus_a.grant, bus_a.serial_out, bus_a.frame_valid, bus_a.frame_start,
         bus_a.frame_last, bus_a.owner, bus_a.busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a grant=%b fv=%b owner=%0d busy=%b expected all 0",
               bus_a.grant, bus_a.frame_valid, bus_a.owner, bus_a.busy);
    end
    checks++;
    if ({bus_b.grant, bus_b.serial_out, bus_b.frame_valid, bus_b.owner, bus_b.busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b grant=%b fv=%b owner=%0d busy=%b expected all 0",
               bus_b.grant, bus_b.frame_valid, bus_b.owner, bus_b.busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  // Cycle-exact trace of one frame plus the earliest follow-on frame.
  task automatic test_single_frame();
    logic [8:0] e_tab [7];
    logic [8:0] obs;
    e_tab = '{9'b1_1_1_0_1_0001, 9'b1_0_0_0_1_0000, 9'b1_1_0_0_1_0000,
              9'b1_1_0_1_1_0000, 9'b0_0_0_0_1_0000, 9'b0_0_0_0_0_0000,
              9'b1_1_1_0_1_0001};
    bus_a.data_in[3:0] = 4'b1011;
    bus_a.req          = 4'b0001;
    exp_q.push_back('{2'd0, 4'b1011});
    exp_q.push_back('{2'd0, 4'b1011});
    for (int c = 0; c < 7; c++) begin
      @(posedge clock); #1;
      obs = {bus_a.frame_valid, bus_a.serial_out, bus_a.frame_start,
             bus_a.frame_last, bus_a.busy, bus_a.grant};
      checks++;
      if (obs !== e_tab[c] || bus_a.owner !== 2'd0) begin
        errors++;
        $display("FAIL single_frame_c%0d got fv,so,fs,fl,busy,grant=%b owner=%0d expected %b owner=0",
                 c + 1, obs, bus_a.owner, e_tab[c]);
      end
    end
    bus_a.req = '0;
    wait_idle();
  endtask

  task automatic test_round_robin();
    int eo[5] = '{0, 1, 2, 3, 0};
    int gc[4] = '{0, 0, 0, 0};
    int nstart = 0;
    int last = 0;
    do_reset();
    bus_a.data_in = {4'h3, 4'hC, 4'h5, 4'hA};
    bus_a.req     = 4'b1111;
    exp_q.push_back('{2'd0, 4'hA});
    exp_q.push_back('{2'd1, 4'h5});
    exp_q.push_back('{2'd2, 4'hC});
    exp_q.push_back('{2'd3, 4'h3});
    exp_q.push_back('{2'd0, 4'hA});
    for (int c = 0; c < 60 && nstart < 5; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) gc[i] += int'(bus_a.grant[i]);
      if (bus_a.frame_start) begin
        checks++;
        if (bus_a.owner !== 2'(eo[nstart]) || bus_a.grant !== (4'b0001 << eo[nstart])) begin
          errors++;
          $display("FAIL rr_owner_%0d got owner=%0d grant=%b expected owner=%0d",
                   nstart, bus_a.owner, bus_a.grant, eo[nstart]);
        end
        if (nstart > 0) begin
          checks++;
          if (cyc - last != 6) begin
            errors++;
            $display("FAIL rr_period_%0d got %0d cycles expected 6", nstart, cyc - last);
          end
        end
        last = cyc;
        nstart++;
      end
    end
    bus_a.req = '0;
    checks++;
    if (nstart != 5) begin
      errors++;
      $display("FAIL rr_timeout got %0d frame starts expected 5", nstart);
    end
    wait_idle();
    checks++;
    if (gc[0] != 2 || gc[1] != 1 || gc[2] != 1 || gc[3] != 1) begin
      errors++;
      $display("FAIL rr_grant_count got %0d,%0d,%0d,%0d expected 2,1,1,1", gc[0], gc[1], gc[2], gc[3]);
    end
  endtask

  task automatic test_two_requesters();
    int eo[3] = '{2, 3, 2};
    int nstart = 0;
    do_reset();
    bus_a.data_in = {4'h9, 4'h6, 4'h0, 4'h0};
    bus_a.req     = 4'b1100;
    exp_q.push_back('{2'd2, 4'h6});
    exp_q.push_back('{2'd3, 4'h9});
    exp_q.push_back('{2'd2, 4'h6});
    for (int c = 0; c < 40 && nstart < 3; c++) begin
      @(posedge clock); #1;
      if (bus_a.frame_start) begin
        checks++;
        if (bus_a.owner !== 2'(eo[nstart]) || bus_a.grant !== (4'b0001 << eo[nstart])) begin
          errors++;
          $display("FAIL pair_owner_%0d got owner=%0d grant=%b expected owner=%0d",
                   nstart, bus_a.owner, bus_a.grant, eo[nstart]);
        end
        nstart++;
      end
    end
    bus_a.req = '0;
    checks++;
    if (nstart != 3) begin
      errors++;
      $display("FAIL pair_timeout got %0d frame starts expected 3", nstart);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    bus_a.data_in = {4'h0, 4'hF, 4'h7, 4'h0};
    bus_a.req     = 4'b0100;
    while (!bus_a.frame_start && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    reset_n   = 1'b0;
    bus_a.req = 4'b0010;
    #1;
    checks++;
    if ({bus_a.grant, bus_a.serial_out, bus_a.frame_valid, bus_a.frame_start,
         bus_a.frame_last, bus_a.owner, bus_a.busy} !== '0) begin
      errors++;
      $display("FAIL abort_outputs grant=%b so=%b fv=%b owner=%0d busy=%b expected all 0",
               bus_a.grant, bus_a.serial_out, bus_a.frame_valid, bus_a.owner, bus_a.busy);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    exp_q.push_back('{2'd1, 4'h7});
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!bus_a.frame_start && n < 10);
    checks++;
    if (bus_a.frame_start !== 1'b1 || bus_a.owner !== 2'd1 || bus_a.grant !== 4'b0010) begin
      errors++;
      $display("FAIL restart_owner got fs=%b owner=%0d grant=%b expected fs=1 owner=1 grant=0010",
               bus_a.frame_start, bus_a.owner, bus_a.grant);
    end
    bus_a.req = '0;
    wait_idle();
  endtask

  task automatic test_drop_in_shift();
    int n = 0;
    int g3 = 0;
    bus_a.data_in = {4'hE, 4'h0, 4'h0, 4'h2};
    bus_a.req     = 4'b0001;
    exp_q.push_back('{2'd0, 4'h2});
    do begin
      @(posedge clock); #1;
      n++;
    end while (!bus_a.frame_start && n < 10);
    bus_a.req = 4'b0000;
    @(posedge clock); #1;
    bus_a.req = 4'b1000;
    @(posedge clock); #1;
    bus_a.req = 4'b0000;
    for (int c = 0; c < 15; c++) begin
      g3 += int'(bus_a.grant[3]);
      @(posedge clock); #1;
    end
    checks++;
    if (g3 != 0 || bus_a.owner !== 2'd0) begin
      errors++;
      $display("FAIL short_pulse got grant3_count=%0d owner=%0d expected 0 and owner=0", g3, bus_a.owner);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_missing got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_gap0();
    int nstart = 0;
    int last_start = 0;
    int last_last = -10;
    logic [WIDTH-1:0] word = '0;
    bus_b.data_in = {4'h0, 4'h0, 4'hD, 4'h0};
    bus_b.req     = 4'b0010;
    for (int c = 0; c < 40 && nstart < 3; c++) begin
      @(posedge clock); #1;
      if (cyc == last_last + 1) begin
        checks++;
        if (bus_b.busy !== 1'b0 || bus_b.frame_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap0_idle got busy=%b fv=%b expected 0,0", bus_b.busy, bus_b.frame_valid);
        end
      end
      if (bus_b.frame_start) begin
        checks++;
        if (bus_b.owner !== 2'd1 || bus_b.grant !== 4'b0010) begin
          errors++;
          $display("FAIL gap0_owner got owner=%0d grant=%b expected 1,0010", bus_b.owner, bus_b.grant);
        end
        if (nstart > 0) begin
          checks++;
          if (cyc - last_start != WIDTH + 1 || cyc - last_last != 2) begin
            errors++;
            $display("FAIL gap0_spacing got period=%0d last_to_start=%0d expected %0d,2",
                     cyc - last_start, cyc - last_last, WIDTH + 1);
          end
        end
        last_start = cyc;
        nstart++;
      end
      if (bus_b.frame_valid) word = {word[WIDTH-2:0], bus_b.serial_out};
      if (bus_b.frame_last) begin
        last_last = cyc;
        checks++;
        if (word !== 4'hD) begin
          errors++;
          $display("FAIL gap0_word got %h expected d", word);
        end
      end
    end
    bus_b.req = '0;
    checks++;
    if (nstart != 3) begin
      errors++;
      $display("FAIL gap0_timeout got %0d frame starts expected 3", nstart);
    end
    repeat (8) @(posedge clock);
    #1;
  endtask

  initial begin
    bus_a.req = '0;
    bus_a.data_in = '0;
    bus_b.req = '0;
    bus_b.data_in = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_two_requesters();
    test_reset_mid_frame();
    test_drop_in_shift();
    test_gap0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
